// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one registered W x W multiplier between
// NREQ requesters and returns each product on a single tagged response channel.
//
// state      | meaning
// rsp_valid  | product for requester rsp_id is held on mul_p, awaiting rsp_ready
// rr_ptr     | requester with highest priority for the next grant
module mul_share_arbiter #(
  parameter int W    = 10,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  output logic                mul_en,
  input  logic [2*W-1:0]      mul_p,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_p
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] scan_id;
  logic           gnt_found;
  logic           can_issue;
  logic           issue;

  // Explicit wrap so a non-power-of-two NREQ never indexes past the last requester.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == IDW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_id   = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
      scan_id = wrap_inc(scan_id);
    end
  end

  // A new issue overwrites mul_p, so it is only allowed once the held product is taken.
  assign can_issue = !rst && (!rsp_valid || rsp_ready);
  assign issue     = can_issue && gnt_found;

  always_comb begin
    req_ready = '0;
    mul_en    = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    if (issue) begin
      req_ready = NREQ'(1) << gnt_id;
      mul_en    = 1'b1;
      mul_a     = req_a[int'(gnt_id)*W +: W];
      mul_b     = req_b[int'(gnt_id)*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (issue) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rr_ptr    <= wrap_inc(gnt_id);
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_p = mul_p;

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one registered W×W unsigned multiplier (the `Binary_mul_*_uni` family, 1-cycle latency, `en`-gated) between NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's `A`/`B`/`en` pins. It tracks which requester owns the product in flight and returns each product on a single tagged response channel with backpressure. It sits between the multiplier instance and its client blocks.

## Interface
- `W`, 10, operand width; the product is 2W bits wide.
- `NREQ`, 4, number of requesters (≥2).
- `IDW`, $clog2(NREQ), width of the requester tag.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has an operand pair pending.
- `req_a`  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- `req_b`  in  NREQ*W  operand B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- `mul_a`  out  W  to multiplier `A`.
- `mul_b`  out  W  to multiplier `B`.
- `mul_en`  out  1  to multiplier `en`; high only in an issue cycle.
- `mul_p`  in  2W  from multiplier `P`; registered, updates on the edge when `en`=1, holds otherwise.
- `rsp_valid`  out  1  `rsp_p`/`rsp_id` are valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  requester that owns `rsp_p`.
- `rsp_p`  out  2W  product; wired directly to `mul_p`.

## Operation
- State:
  - `rr_ptr` (IDW): highest-priority requester.
  - `rsp_valid` (1).
  - `rsp_id` (IDW).
- `can_issue` = !rst && (!rsp_valid || rsp_ready).
- Grant: the first requester i with `req_valid[i]`=1, scanning `rr_ptr`, `rr_ptr`+1, … modulo NREQ. `req_ready[i]` = `can_issue` && (i is the grant).
- Issue cycle (any `req_ready` bit high):
  - `mul_en`=1.
  - `mul_a`/`mul_b` = granted requester's operands.
  - On the edge: `rsp_valid`←1, `rsp_id`←granted i, `rr_ptr`←(i+1) mod NREQ.
- No issue cycle:
  - `mul_en`=0, `mul_a`=`mul_b`=0.
  - `rr_ptr` holds.
  - If `rsp_valid` && `rsp_ready`: `rsp_valid`←0.
  - Otherwise `rsp_valid`/`rsp_id` hold.
- Stall: while `rsp_valid`=1 and `rsp_ready`=0:
  - no issue; `mul_en`=0;
  - the multiplier holds `P`, so `rsp_p` stays stable.
- Requester rules:
  - Once `req_valid[i]` is raised it must stay high, with `req_a`/`req_b` stable, until `req_ready[i]`=1.
  - Violation is undefined.
- Arithmetic: unsigned, exact, with no truncation. The maximum product is (2^W−1)^2, which fits in 2W bits. The product is computed by the multiplier; the arbiter never alters it.
- Non-power-of-two NREQ: the `rr_ptr` increment wraps from NREQ−1 to 0 explicitly, not by bit overflow.

## Timing
- Reset values (the edge after `rst`=1):
  - `rsp_valid`=0, `rr_ptr`=0, `rsp_id`=0.
  - While `rst`=1: `req_ready`=0 and `mul_en`=0 (combinationally gated).
- Reset mid-operation: an in-flight or held product is discarded, and `rsp_valid`=0 after the reset edge. No ready is issued during reset.
- Latency: accepted at edge t → `rsp_valid`=1 with the correct `rsp_p` from t+ (one cycle).
- Throughput: one product per cycle while `rsp_ready`=1. Simultaneous response-consume and new-issue in the same cycle is required.
- Response handshake completes on an edge where `rsp_valid`&&`rsp_ready`=1. `rsp_id`/`rsp_p` stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- Single requester active: it is granted every cycle; `rr_ptr` tracks it.
- All requesters valid continuously: grants rotate 0,1,…,NREQ−1,0. No requester waits more than NREQ−1 issue cycles.
- `rsp_ready` high while `rsp_valid`=0 has no effect.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with all `req_valid` high → `req_ready`=0, `mul_en`=0, `rsp_valid`=0. After release, the first grant goes to requester 0.
- Single op: requester 2 sends A=1023, B=1023, `rsp_ready`=1 → `req_ready`=4'b0100 for one cycle, then next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_p`=1046529.
- Round-robin fairness: all 4 valid continuously with A=i+1, B=10, `rsp_ready`=1 → ids 0,1,2,3,0…, products 10,20,30,40, one per cycle with no bubbles.
- Backpressure: accept (A=5, B=7) from requester 1, hold `rsp_ready`=0 for 4 cycles with requesters 0 and 3 valid → `rsp_p`=35, `rsp_id`=1 stable. `mul_en`=0 and `req_ready`=0 throughout. The cycle `rsp_ready`=1 grants requester 3 (`rr_ptr`=2).
- Reset mid-flight: issue (A=100, B=3), assert `rst` in the following cycle → `rsp_valid`=0 after the edge, the result is never presented, and `rr_ptr`=0.
- Exhaustive sweep: a single requester cycles all 1024×1024 operand pairs with random `rsp_ready` → every response equals A*B in order, with `rsp_id`=0 throughout.
